accumulator_control_unit: RTL and testbench

Multi-cycle fetch/decode/execute sequencer for the team's 16-bit accumulator machine. Owns the PC, IR and accumulator. Drives the existing synchronous-read main memory (16Ki x 16) and the combinational 4-bit-opcode ALU, sharing the single memory port between instruction fetch, operand read and store. Sits between the top-level run control (start/halted) and the memory/ALU datapath.

---
 rtl/accumulator_control_unit.sv | 110 +++++++++++
 tb/tb_accumulator_control_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_control_unit.sv
// accumulator_control_unit: multi-cycle fetch/decode/execute sequencer owning pc, ir and acc for the 16-bit accumulator machine
module accumulator_control_unit #(
  parameter int MEM_DEPTH = 16384
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  output logic [15:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  output logic        o_mem_we,
  input  logic [15:0] i_mem_rdata,
  output logic [3:0]  o_alu_opcode,
  output logic [15:0] o_alu_op1,
  output logic [15:0] o_alu_op2,
  input  logic [15:0] i_alu_result,
  output logic [15:0] o_acc,
  output logic [15:0] o_pc,
  output logic        o_busy,
  output logic        o_halted,
  output logic        o_error
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_MREAD, S_MWRITE, S_EXEC, S_HALT} state_t;
  localparam logic [3:0] OP_LOAD = 4'h1, OP_STORE = 4'h2, OP_ALU = 4'h3, OP_JUMP = 4'h4,
                         OP_JZ = 4'h5, OP_JNZ = 4'h6, OP_LOADI = 4'h7;
  state_t      r_state, w_state_d;
  logic [15:0] r_pc, r_ir, r_acc, w_pc_d, w_ir_d, w_acc_d, w_addr12, w_addr8, w_pc_inc;
  logic        r_error, w_error_d, w_take;
  logic [3:0]  w_op, w_dec_op;
  assign w_op     = r_ir[15:12];
  assign w_dec_op = i_mem_rdata[15:12];
  assign w_addr12 = {4'b0, r_ir[11:0]};
  assign w_addr8  = {8'b0, r_ir[7:0]};
  assign w_pc_inc = (r_pc == 16'(MEM_DEPTH - 1)) ? 16'd0 : r_pc + 16'd1;
  assign w_take   = (w_op == OP_JUMP) || (w_op == OP_JZ && r_acc == 16'd0) || (w_op == OP_JNZ && r_acc != 16'd0);
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_acc   <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      r_ir    <= w_ir_d;
      r_acc   <= w_acc_d;
      r_error <= w_error_d;
    end
  end
  // Decode looks at the fetched word directly; ir only becomes valid from S_MREAD/S_MWRITE/S_EXEC on
  always_comb begin
    w_state_d    = r_state;
    w_pc_d       = r_pc;
    w_ir_d       = r_ir;
    w_acc_d      = r_acc;
    w_error_d    = r_error;
    o_mem_addr   = '0;
    o_mem_we     = 1'b0;
    o_alu_opcode = '0;
    case (r_state)
      S_IDLE: begin
        w_state_d = i_start ? S_FETCH : S_IDLE;
        w_pc_d    = i_start ? 16'd0 : r_pc;
      end
      S_FETCH: begin
        o_mem_addr = r_pc;
        w_state_d  = S_DECODE;
      end
      S_DECODE: begin
        w_ir_d    = i_mem_rdata;
        w_pc_d    = w_pc_inc;
        w_error_d = w_dec_op[3];
        w_state_d = (w_dec_op == OP_LOAD || w_dec_op == OP_ALU) ? S_MREAD :
                    (w_dec_op == OP_STORE) ? S_MWRITE :
                    (w_dec_op inside {OP_JUMP, OP_JZ, OP_JNZ, OP_LOADI}) ? S_EXEC : S_HALT;
      end
      S_MREAD: begin
        o_mem_addr = (w_op == OP_ALU) ? w_addr8 : w_addr12;
        w_state_d  = S_EXEC;
      end
      S_MWRITE: begin
        o_mem_addr = w_addr12;
        o_mem_we   = 1'b1;
        w_state_d  = S_FETCH;
      end
      S_EXEC: begin
        o_alu_opcode = (w_op == OP_ALU) ? r_ir[11:8] : 4'd0;
        w_acc_d      = (w_op == OP_LOAD) ? i_mem_rdata :
                       (w_op == OP_ALU) ? i_alu_result :
                       (w_op == OP_LOADI) ? w_addr12 : r_acc;
        w_pc_d       = w_take ? w_addr12 : r_pc;
        w_state_d    = S_FETCH;
      end
      S_HALT: begin
        w_state_d = i_start ? S_FETCH : S_HALT;
        w_pc_d    = i_start ? 16'd0 : r_pc;
        w_error_d = i_start ? 1'b0 : r_error;
      end
      default: w_state_d = S_IDLE;
    endcase
  end
  assign o_mem_wdata = r_acc;
  assign o_alu_op1   = r_acc;
  assign o_alu_op2   = i_mem_rdata;
  assign o_acc       = r_acc;
  assign o_pc        = r_pc;
  assign o_busy      = (r_state != S_IDLE) && (r_state != S_HALT);
  assign o_halted    = (r_state == S_HALT);
  assign o_error     = r_error;
endmodule

// File: tb/tb_accumulator_control_unit.sv
// tb_accumulator_control_unit: program-level bench with a memory/ALU model and a write/accumulator scoreboard
module tb_accumulator_control_unit;
  logic        clk = 0, reset = 0, start = 0;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, alu_op1, alu_op2, alu_result, acc, pc;
  logic        mem_we, busy, halted, error;
  logic [3:0]  alu_opcode;
  logic [15:0] mem [16384];
  logic        ld_en = 0, fill_en = 0;
  logic [15:0] ld_addr = 0, ld_data = 0;
  int          n_checks = 0, n_pass = 0, n_sub = 0;
  logic [31:0] exp_wr[$];
  logic [15:0] exp_acc[$];

  accumulator_control_unit dut (
    .i_clk(clk), .i_reset(reset), .i_start(start),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we), .i_mem_rdata(mem_rdata),
    .o_alu_opcode(alu_opcode), .o_alu_op1(alu_op1), .o_alu_op2(alu_op2), .i_alu_result(alu_result),
    .o_acc(acc), .o_pc(pc), .o_busy(busy), .o_halted(halted), .o_error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fill_en) for (int i = 0; i < 16384; i++) mem[i] <= ld_data;
    else if (ld_en) mem[ld_addr[13:0]] <= ld_data;
    else if (mem_we) mem[mem_addr[13:0]] <= mem_wdata;
    if (!mem_we) mem_rdata <= mem[mem_addr[13:0]];
  end

  assign alu_result = (alu_opcode == 4'd0) ? alu_op1 + alu_op2 :
                      (alu_opcode == 4'd1) ? alu_op1 - alu_op2 :
                      (alu_opcode == 4'd2) ? (alu_op1 & alu_op2) : (alu_op1 | alu_op2);

  task automatic load(input logic [15:0] a, input logic [15:0] d);
    ld_addr = a; ld_data = d; ld_en = 1;
    @(posedge clk); #1 ld_en = 0;
  endtask

  task automatic fill(input logic [15:0] d);
    ld_data = d; fill_en = 1;
    @(posedge clk); #1 fill_en = 0;
  endtask

  task automatic pulse_start;
    start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic do_reset;
    reset = 1; #3;
    @(posedge clk); #1 reset = 0;
  endtask

  // Scoreboard consumer: pops expected writes / accumulator updates as the DUT produces them
  task automatic run_to_halt(input int limit, output int cycles);
    logic [15:0] prev;
    logic [31:0] e;
    cycles = 0;
    prev = acc;
    while (!halted && cycles < limit) begin
      @(posedge clk); #1 cycles++;
      if (mem_we) begin
        n_checks++;
        if (exp_wr.size() == 0) $display("FAIL sb_write unexpected addr=%h data=%h, none expected", mem_addr, mem_wdata);
        else begin
          e = exp_wr.pop_front();
          if ({mem_addr, mem_wdata} !== e) $display("FAIL sb_write got %h/%h want %h/%h", mem_addr, mem_wdata, e[31:16], e[15:0]);
          else n_pass++;
        end
      end
      if (acc !== prev) begin
        n_checks++;
        if (exp_acc.size() == 0) $display("FAIL sb_acc unexpected acc=%h, none expected", acc);
        else begin
          e[15:0] = exp_acc.pop_front();
          if (acc !== e[15:0]) $display("FAIL sb_acc got %h want %h", acc, e[15:0]);
          else n_pass++;
        end
      end
      prev = acc;
      if (alu_opcode == 4'd1) n_sub++;
    end
    n_checks++;
    if (exp_wr.size() != 0 || exp_acc.size() != 0) $display("FAIL sb_drain left writes=%0d acc=%0d want 0/0", exp_wr.size(), exp_acc.size());
    else n_pass++;
    exp_wr.delete();
    exp_acc.delete();
  endtask

  task automatic test_reset;
    #2 reset = 1; start = 1;
    @(posedge clk); #1;
    n_checks++; if ({mem_addr, mem_wdata, mem_we, alu_opcode, acc, pc, busy, halted, error} !== 72'd0) $display("FAIL reset_outputs got %h want 0", {mem_addr, mem_wdata, mem_we, alu_opcode, acc, pc, busy, halted, error}); else n_pass++;
    start = 0; reset = 0;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_idle_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_store;
    int cyc;
    fill(16'h0000);
    load(16'h0, 16'h7005); load(16'h1, 16'h2010); load(16'h2, 16'h0000);
    exp_wr.push_back({16'h0010, 16'h0005});
    exp_acc.push_back(16'h0005);
    pulse_start;
    n_checks++; if ({busy, mem_addr} !== {1'b1, 16'h0}) $display("FAIL start_fetch got busy=%b addr=%h want 1/0000", busy, mem_addr); else n_pass++;
    run_to_halt(50, cyc);
    n_checks++; if (cyc !== 8) $display("FAIL store_cycles got %0d want 8", cyc); else n_pass++;
    n_checks++; if (acc !== 16'h5) $display("FAIL store_acc got %h want 0005", acc); else n_pass++;
    n_checks++; if (pc !== 16'h3) $display("FAIL store_pc got %h want 0003", pc); else n_pass++;
    n_checks++; if ({halted, busy, error} !== 3'b100) $display("FAIL store_flags got %b want 100", {halted, busy, error}); else n_pass++;
    n_checks++; if (mem[16'h10] !== 16'h5) $display("FAIL store_mem got %h want 0005", mem[16'h10]); else n_pass++;
  endtask

  task automatic test_illegal;
    int cyc;
    load(16'h0, 16'hF123);
    pulse_start;
    run_to_halt(10, cyc);
    n_checks++; if (cyc !== 2) $display("FAIL illegal_cycles got %0d want 2", cyc); else n_pass++;
    n_checks++; if ({halted, error} !== 2'b11) $display("FAIL illegal_flags got %b want 11", {halted, error}); else n_pass++;
    n_checks++; if (pc !== 16'h1) $display("FAIL illegal_pc got %h want 0001", pc); else n_pass++;
    n_checks++; if (acc !== 16'h5) $display("FAIL illegal_acc got %h want 0005", acc); else n_pass++;
    pulse_start;
    n_checks++; if ({error, busy, pc, mem_addr} !== {2'b01, 32'h0}) $display("FAIL illegal_restart got err=%b busy=%b pc=%h addr=%h want 0/1/0000/0000", error, busy, pc, mem_addr); else n_pass++;
    run_to_halt(10, cyc);
    n_checks++; if (error !== 1'b1) $display("FAIL illegal_again got %b want 1", error); else n_pass++;
  endtask

  task automatic test_alu;
    int cyc;
    load(16'h0, 16'h7003); load(16'h1, 16'h3020); load(16'h2, 16'h3121); load(16'h3, 16'h0000);
    load(16'h20, 16'h0004); load(16'h21, 16'h0002);
    exp_acc.push_back(16'h3); exp_acc.push_back(16'h7); exp_acc.push_back(16'h5);
    n_sub = 0;
    pulse_start;
    run_to_halt(50, cyc);
    n_checks++; if (cyc !== 13) $display("FAIL alu_cycles got %0d want 13", cyc); else n_pass++;
    n_checks++; if (acc !== 16'h5) $display("FAIL alu_acc got %h want 0005", acc); else n_pass++;
    n_checks++; if (n_sub !== 1) $display("FAIL alu_sub_cycles got %0d want 1", n_sub); else n_pass++;
    n_checks++; if (pc !== 16'h4) $display("FAIL alu_pc got %h want 0004", pc); else n_pass++;
  endtask

  task automatic test_countdown;
    int cyc;
    load(16'h0, 16'h7003); load(16'h1, 16'h3110); load(16'h2, 16'h5004); load(16'h3, 16'h4001);
    load(16'h4, 16'h0000); load(16'h10, 16'h0001);
    exp_acc.push_back(16'h3); exp_acc.push_back(16'h2); exp_acc.push_back(16'h1); exp_acc.push_back(16'h0);
    n_sub = 0;
    pulse_start;
    run_to_halt(100, cyc);
    n_checks++; if (cyc !== 32) $display("FAIL loop_cycles got %0d want 32", cyc); else n_pass++;
    n_checks++; if (n_sub !== 3) $display("FAIL loop_iters got %0d want 3", n_sub); else n_pass++;
    n_checks++; if ({acc, pc} !== {16'h0, 16'h5}) $display("FAIL loop_end got acc=%h pc=%h want 0000/0005", acc, pc); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int cyc;
    load(16'h0, 16'h7001); load(16'h1, 16'h4003); load(16'h2, 16'h0000); load(16'h3, 16'h7002); load(16'h4, 16'h0000);
    exp_acc.push_back(16'h1); exp_acc.push_back(16'h2);
    pulse_start;
    fork
      run_to_halt(50, cyc);
      begin
        repeat (3) @(posedge clk);
        #2 start = 1;
        repeat (3) @(posedge clk);
        #2 start = 0;
      end
    join
    n_checks++; if (cyc !== 11) $display("FAIL busy_start_cycles got %0d want 11", cyc); else n_pass++;
    n_checks++; if ({acc, pc} !== {16'h2, 16'h5}) $display("FAIL busy_start_end got acc=%h pc=%h want 0002/0005", acc, pc); else n_pass++;
  endtask

  task automatic test_pc_wrap;
    int cyc, k;
    do_reset;
    fill(16'h7001);
    load(16'h0, 16'h6003); load(16'h1, 16'h4FFF); load(16'h3, 16'h0000); load(16'h3FFF, 16'h7042);
    pulse_start;
    k = 0;
    while (pc !== 16'h3FFF && k < 60000) begin @(posedge clk); #1 k++; end
    n_checks++; if (pc !== 16'h3FFF) $display("FAIL wrap_reach got %h want 3fff", pc); else n_pass++;
    k = 0;
    while (pc === 16'h3FFF && k < 5) begin @(posedge clk); #1 k++; end
    n_checks++; if (pc !== 16'h0) $display("FAIL wrap_pc got %h want 0000", pc); else n_pass++;
    exp_acc.push_back(16'h0042);
    run_to_halt(20, cyc);
    n_checks++; if ({acc, pc, cyc[7:0]} !== {16'h42, 16'h4, 8'd6}) $display("FAIL wrap_end got acc=%h pc=%h cyc=%0d want 0042/0004/6", acc, pc, cyc); else n_pass++;
  endtask

  task automatic test_reset_mwrite;
    int k;
    load(16'h0, 16'h7009); load(16'h1, 16'h2010); load(16'h2, 16'h0000); load(16'h10, 16'hABCD);
    pulse_start;
    k = 0;
    while (!mem_we && k < 20) begin @(posedge clk); #1 k++; end
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h10) $display("FAIL rst_reach_mwrite got we=%b addr=%h want 1/0010", mem_we, mem_addr); else n_pass++;
    reset = 1; #1;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL rst_we_drop got %b want 0", mem_we); else n_pass++;
    n_checks++; if ({mem_addr, mem_wdata, mem_we, alu_opcode, acc, pc, busy, halted, error} !== 72'd0) $display("FAIL rst_outputs got %h want 0", {mem_addr, mem_wdata, mem_we, alu_opcode, acc, pc, busy, halted, error}); else n_pass++;
    @(posedge clk); @(posedge clk); #1;
    n_checks++; if (mem[16'h10] !== 16'hABCD) $display("FAIL rst_mem got %h want abcd", mem[16'h10]); else n_pass++;
    reset = 0;
  endtask

  initial begin
    test_reset;
    test_store;
    test_illegal;
    test_alu;
    test_countdown;
    test_back_to_back;
    test_pc_wrap;
    test_reset_mwrite;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
